// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with write-to-read bypass and a busy scoreboard.
// Stall blocks issue on RAW/WAW hazards; pending_cnt tracks outstanding producers.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic              issue_use_a,
  input  logic              issue_use_b,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  logic wr_ok;
  logic zero_a, zero_b, zero_d;
  logic hit_a, hit_b, hit_d;
  logic busy_d;
  logic issue_ok;

  assign wr_ok  = wr_en & ~(ZR & (wr_addr == '0));

  assign zero_a = ZR & (rd_addr_a == '0);
  assign zero_b = ZR & (rd_addr_b == '0);
  assign zero_d = ZR & (issue_dst == '0);

  // A writeback in flight this cycle satisfies a reader when bypass is on
  assign hit_a  = BYP & wr_en & (wr_addr == rd_addr_a);
  assign hit_b  = BYP & wr_en & (wr_addr == rd_addr_b);
  assign hit_d  = BYP & wr_en & (wr_addr == issue_dst);

  assign rd_data_a = (rst | zero_a) ? '0 :
                     hit_a ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (rst | zero_b) ? '0 :
                     hit_b ? wr_data : regs[rd_addr_b];

  assign busy_a = ~rst & ~zero_a & busy[rd_addr_a] & ~hit_a;
  assign busy_b = ~rst & ~zero_b & busy[rd_addr_b] & ~hit_b;
  assign busy_d = ~rst & ~zero_d & busy[issue_dst] & ~hit_d;

  assign stall = ~rst & issue_en &
                 ((issue_use_a & busy_a) |
                  (issue_use_b & busy_b) |
                  (issue_wr & busy_d));

  assign issue_ok = issue_en & ~stall & issue_wr;

  // Set beats clear so a freshly issued producer stays pending
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b0;
      if (issue_ok && issue_dst == ADDR_W'(i))
        busy_nxt[i] = 1'b1;
      if (ZR && i == 0)
        busy_nxt[i] = 1'b0;
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; a second instance runs with
// bypass disabled on the same stimulus.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [15:0] nb_data_a, nb_data_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        issue_en, issue_use_a, issue_use_b, issue_wr;
  logic [3:0]  issue_dst;
  logic        busy_a, busy_b, stall;
  logic        nb_busy_a, nb_busy_b, nb_stall;
  logic [4:0]  pending_cnt, nb_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_use_a(issue_use_a),
    .issue_use_b(issue_use_b), .issue_wr(issue_wr),
    .issue_dst(issue_dst),
    .busy_a(busy_a), .busy_b(busy_b), .stall(stall),
    .pending_cnt(pending_cnt)
  );

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)
  ) u_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_data_a), .rd_data_b(nb_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_use_a(issue_use_a),
    .issue_use_b(issue_use_b), .issue_wr(issue_wr),
    .issue_dst(issue_dst),
    .busy_a(nb_busy_a), .busy_b(nb_busy_b), .stall(nb_stall),
    .pending_cnt(nb_pending)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en       = 1'b0;
    issue_en    = 1'b0;
    issue_use_a = 1'b0;
    issue_use_b = 1'b0;
    issue_wr    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_addr = '0; wr_data = '0; issue_dst = '0;
    idle();

    // Outputs quiet while held in reset, even with a request present
    issue_en = 1'b1; issue_wr = 1'b1; issue_dst = 4'd1;
    #3;
    chk("rst_rd_a", 32'(rd_data_a), 32'h0);
    chk("rst_pend", 32'(pending_cnt), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Write 0xBEEF to R5 and make R2 busy, then reset mid-cycle
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    issue_en = 1'b1; issue_wr = 1'b1; issue_dst = 4'd2;
    tick();
    idle();
    rd_addr_a = 4'd5;
    #1;
    chk("pre_rst_r5", 32'(rd_data_a), 32'hBEEF);
    chk("pre_rst_pend", 32'(pending_cnt), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_r5", 32'(rd_data_a), 32'h0);
    chk("async_rst_pend", 32'(pending_cnt), 32'h0);
    tick();
    rst = 1'b0;

    // Plain write then read on both ports
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    tick();
    wr_addr = 4'd15; wr_data = 16'hFFFF;
    tick();
    idle();
    rd_addr_a = 4'd3; rd_addr_b = 4'd15;
    #1;
    chk("rd_a_r3", 32'(rd_data_a), 32'h1234);
    chk("rd_b_r15", 32'(rd_data_b), 32'hFFFF);
    rd_addr_b = 4'd3;
    #1;
    chk("rd_b_same", 32'(rd_data_b), 32'h1234);

    // Same-cycle bypass versus old value
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hA5A5;
    rd_addr_a = 4'd7;
    #1;
    chk("byp_r7", 32'(rd_data_a), 32'hA5A5);
    chk("nobyp_r7", 32'(nb_data_a), 32'h0);
    tick();
    idle();
    #1;
    chk("nobyp_r7_next", 32'(nb_data_a), 32'hA5A5);

    // R0 is hard-wired zero and never busy
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h5555;
    issue_en = 1'b1; issue_wr = 1'b1; issue_dst = 4'd0;
    rd_addr_a = 4'd0;
    #1;
    chk("r0_byp", 32'(rd_data_a), 32'h0);
    chk("r0_stall", 32'(stall), 32'h0);
    tick();
    idle();
    #1;
    chk("r0_rd", 32'(rd_data_a), 32'h0);
    chk("r0_pend", 32'(pending_cnt), 32'h0);

    // RAW hazard on R4
    issue_en = 1'b1; issue_wr = 1'b1; issue_dst = 4'd4;
    #1;
    chk("h_issue_stall", 32'(stall), 32'h0);
    tick();
    idle();
    rd_addr_a = 4'd4;
    #1;
    chk("h_pend1", 32'(pending_cnt), 32'h1);
    chk("h_busy_a", 32'(busy_a), 32'h1);
    issue_en = 1'b1; issue_use_a = 1'b1;
    issue_wr = 1'b1; issue_dst = 4'd9;
    #1;
    chk("h_stall", 32'(stall), 32'h1);
    tick();
    chk("h_pend_hold", 32'(pending_cnt), 32'h1);
    issue_wr = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
    #1;
    chk("h_wb_busy_a", 32'(busy_a), 32'h0);
    chk("h_wb_stall", 32'(stall), 32'h0);
    chk("h_wb_data", 32'(rd_data_a), 32'h4444);
    chk("h_nb_busy_a", 32'(nb_busy_a), 32'h1);
    chk("h_nb_stall", 32'(nb_stall), 32'h1);
    tick();
    idle();
    #1;
    chk("h_pend0", 32'(pending_cnt), 32'h0);
    chk("h_nb_pend0", 32'(nb_pending), 32'h0);

    // Set/clear collision on R6
    issue_en = 1'b1; issue_wr = 1'b1; issue_dst = 4'd6;
    tick();
    chk("c_pend1", 32'(pending_cnt), 32'h1);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h6666;
    #1;
    chk("c_stall", 32'(stall), 32'h0);
    chk("c_nb_stall", 32'(nb_stall), 32'h1);
    tick();
    idle();
    rd_addr_a = 4'd6;
    #1;
    chk("c_pend_keep", 32'(pending_cnt), 32'h1);
    chk("c_busy6", 32'(busy_a), 32'h1);
    chk("c_nb_pend0", 32'(nb_pending), 32'h0);

    // Set R8 while clearing R6: count unchanged, bits swap
    issue_en = 1'b1; issue_wr = 1'b1; issue_dst = 4'd8;
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h6006;
    tick();
    idle();
    rd_addr_a = 4'd8; rd_addr_b = 4'd6;
    #1;
    chk("s_pend", 32'(pending_cnt), 32'h1);
    chk("s_busy8", 32'(busy_a), 32'h1);
    chk("s_busy6", 32'(busy_b), 32'h0);
    chk("s_r6", 32'(rd_data_b), 32'h6006);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
